// File: rtl/adder_pkg.sv
// Shared constants and helpers for the segmented pipelined adder.
package adder_pkg;

  localparam int DEFAULT_SEG = 4;

  function automatic int stages_f(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/pipe_adder_seg_adder.sv
// Combinational SEG-bit adder slice: sum, carry out, and carry into its MSB.
module seg_adder
  import adder_pkg::*;
#(
  parameter int SEG = DEFAULT_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           cm
);

  logic [SEG:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
  assign s   = sum[SEG-1:0];
  assign co  = sum[SEG];
  // The MSB sum bit is a^b^carry_in, so the carry into the MSB falls out by XOR.
  assign cm  = sum[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder, one SEG-bit carry segment per register stage,
// with valid/ready backpressure. Define PIPE_ADDER_OVF_EN to add the ovf output.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = DEFAULT_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = stages_f(WIDTH, SEG);

  if (WIDTH % SEG != 0) begin : g_bad_width
    $error("pipe_adder: WIDTH must be a multiple of SEG");
  end

  logic [STAGES-1:0]            vld;
  logic [STAGES-1:0]            up;
  logic [STAGES:0]              go;
  logic [STAGES-1:0][WIDTH-1:0] a_p;
  logic [STAGES-1:0][WIDTH-1:0] b_p;
  logic [STAGES-1:0][WIDTH-1:0] s_p;
  logic [STAGES-1:0]            c_p;
  logic [STAGES-1:0]            co_w;
  logic [STAGES-1:0]            cm_w;

  // go[k]: stage k may load this cycle (empty, or its successor moves on).
  always_comb begin
    go         = '0;
    go[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      go[k] = ~vld[k] | go[k+1];
    end
  end

  always_comb begin
    up    = vld << 1;
    up[0] = in_valid;
  end

  assign in_ready  = go[0];
  assign out_valid = vld[STAGES-1];
  assign s         = s_p[STAGES-1];
  assign co        = c_p[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (go[k]) vld[k] <= up[k];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;

    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] s_src;
    logic [WIDTH-1:0] s_nxt;
    logic             c_src;
    logic [SEG-1:0]   seg_sum;

    if (k == 0) begin : g_head
      assign a_src = a;
      assign b_src = b;
      assign s_src = '0;
      assign c_src = ci;
    end else begin : g_body
      assign a_src = a_p[k-1];
      assign b_src = b_p[k-1];
      assign s_src = s_p[k-1];
      assign c_src = c_p[k-1];
    end

    seg_adder #(.SEG(SEG)) u_seg (
      .a  (a_src[LO +: SEG]),
      .b  (b_src[LO +: SEG]),
      .ci (c_src),
      .s  (seg_sum),
      .co (co_w[k]),
      .cm (cm_w[k])
    );

    always_comb begin
      s_nxt            = s_src;
      s_nxt[LO +: SEG] = seg_sum;
    end

    // Stage k register: operands skew forward, finished sum bits deskew forward.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_p[k] <= '0;
        b_p[k] <= '0;
        s_p[k] <= '0;
        c_p[k] <= 1'b0;
      end else if (go[k] & up[k]) begin
        a_p[k] <= a_src;
        b_p[k] <= b_src;
        s_p[k] <= s_nxt;
        c_p[k] <= co_w[k];
      end
    end
  end

`ifdef PIPE_ADDER_OVF_EN
  logic ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (go[STAGES-1] & up[STAGES-1]) begin
      ovf_r <= cm_w[STAGES-1] ^ co_w[STAGES-1];
    end
  end

  assign ovf = ovf_r;
`endif

  // Already-consumed operand segments and per-segment MSB carries are dead by design.
  logic unused_bits;
  assign unused_bits = ^{a_p, b_p, cm_w};

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: scoreboard of a+b+ci results, stall, reset and SEG==WIDTH cases.
module tb_pipe_adder;

  localparam int WIDTH  = 16;
  localparam int SEG    = 4;
  localparam int STAGES = WIDTH / SEG;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b1;
  logic             ci        = 1'b0;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             in_ready, out_valid, co;
  logic [WIDTH-1:0] s;
  logic             in_ready1, out_valid1, co1;
  logic [WIDTH-1:0] s1;
`ifdef PIPE_ADDER_OVF_EN
  logic             ovf, ovf1;
`endif

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   pop_cnt = 0;

  pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  pipe_adder #(.WIDTH(WIDTH), .SEG(WIDTH)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid1), .out_ready(out_ready),
    .s(s1), .co(co1)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c);
    logic [WIDTH:0] t;
    exp_t           e;
    t     = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    e.s   = t[WIDTH-1:0];
    e.co  = t[WIDTH];
    e.ovf = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
    return e;
  endfunction

  // Scoreboard: handshakes sampled mid-cycle, i.e. the values the next rising edge sees.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(sb.size()), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sum", 32'(s), 32'(e.s));
          check("carry", 32'(co), 32'(e.co));
`ifdef PIPE_ADDER_OVF_EN
          check("ovf", 32'(ovf), 32'(e.ovf));
`endif
          pop_cnt++;
          pop_cyc.push_back(cyc);
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, ci));
    end
  end

  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
    int n;
    n        = 0;
    a        = x;
    b        = y;
    ci       = c;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 32'(n), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int               lat, acc, seen, p0;
    logic             took, held, hc;
    logic [WIDTH-1:0] hs;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_s", 32'(s), 0);
    check("rst_co", 32'(co), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(16'hFFFF, 16'h0001, 1'b0);
    wait_out(lat);
    check("t1_latency", 32'(lat), STAGES);
    check("t1_s", 32'(s), 32'h0000);
    check("t1_co", 32'(co), 1);
`ifdef PIPE_ADDER_OVF_EN
    check("t1_ovf", 32'(ovf), 0);
`endif
    repeat (6) @(posedge clk);
    #1;

    send(16'h8000, 16'h8000, 1'b0);
    check("seg16_valid", 32'(out_valid1), 1);
    check("seg16_s", 32'(s1), 32'h0000);
    check("seg16_co", 32'(co1), 1);
    repeat (6) @(posedge clk);
    #1;

    send(16'h1234, 16'h4321, 1'b1);
    wait_out(lat);
    check("t2_latency", 32'(lat), STAGES);
    check("t2_s", 32'(s), 32'h5556);
    check("t2_co", 32'(co), 0);
    repeat (6) @(posedge clk);
    #1;

`ifdef PIPE_ADDER_OVF_EN
    send(16'h7FFF, 16'h0001, 1'b0);
    wait_out(lat);
    check("ovf_pos", 32'(ovf), 1);
    repeat (6) @(posedge clk);
    #1;
`endif

    pop_cyc.delete();
    for (int i = 0; i < 8; i++) send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    repeat (10) @(posedge clk);
    #1;
    check("b2b_count", 32'(pop_cyc.size()), 8);
    if (pop_cyc.size() == 8) check("b2b_consecutive", 32'(pop_cyc[7] - pop_cyc[0]), 7);

    out_ready = 1'b0;
    acc       = 0;
    held      = 1'b0;
    hs        = '0;
    hc        = 1'b0;
    a         = 16'($urandom);
    b         = 16'($urandom);
    ci        = 1'($urandom_range(0, 1));
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      took = in_ready;
      if (took) acc++;
      if (out_valid) begin
        if (held) begin
          check("stall_s_stable", 32'(s), 32'(hs));
          check("stall_co_stable", 32'(co), 32'(hc));
        end else begin
          hs   = s;
          hc   = co;
          held = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      if (took) begin
        a  = 16'($urandom);
        b  = 16'($urandom);
        ci = 1'($urandom_range(0, 1));
      end
    end
    check("stall_accepts", 32'(acc), STAGES);
    check("stall_in_ready", 32'(in_ready), 0);
    check("stall_out_valid", 32'(out_valid), 1);

    p0        = pop_cnt;
    out_ready = 1'b1;
    #1;
    check("full_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("full_still_valid", 32'(out_valid), 1);
    repeat (12) @(posedge clk);
    #1;
    check("drain_count", 32'(pop_cnt - p0), STAGES + 1);
    check("drain_empty", 32'(sb.size()), 0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (6) begin
      a = 16'($urandom);
      b = 16'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("prereset_full", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 0);
    check("async_s", 32'(s), 0);
    check("async_co", 32'(co), 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    check("post_rst_in_ready", 32'(in_ready), 1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_stale_result", 32'(seen), 0);
    @(posedge clk);
    #1;

    send(16'hA5A5, 16'h5A5B, 1'b0);
    wait_out(lat);
    check("post_rst_latency", 32'(lat), STAGES);
    repeat (6) @(posedge clk);
    #1;
    check("final_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
